// File: rtl/udm_bus_initiator.sv
// rtl/udm_bus_initiator.sv - single-outstanding udm bus initiator with read response port and timeouts
module udm_bus_initiator #(
  parameter int unsigned BUS_TIMEOUT   = 1024,
  parameter logic [31:0] TIMEOUT_RDATA = 32'hDEADBEEF
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        cmd_req_i,
  input  logic        cmd_we_i,
  input  logic [31:0] cmd_addr_bi,
  input  logic [3:0]  cmd_be_bi,
  input  logic [31:0] cmd_wdata_bi,
  output logic        cmd_ack_o,
  output logic        resp_req_o,
  output logic [31:0] resp_rdata_bo,
  output logic        resp_err_o,
  input  logic        resp_ack_i,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [31:0] bus_addr_bo,
  output logic [3:0]  bus_be_bo,
  output logic [31:0] bus_wdata_bo,
  input  logic        bus_ack_i,
  input  logic        bus_resp_i,
  input  logic [31:0] bus_rdata_bi,
  output logic        busy_o,
  output logic [7:0]  err_cnt_bo
);

  localparam int unsigned TW = $clog2(BUS_TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_REQ       = 2'd1,
    S_WAIT_RESP = 2'd2,
    S_RESP_OUT  = 2'd3
  } state_t;

  state_t        r_state;
  state_t        w_next_state;
  logic [TW-1:0] r_timer;
  logic          r_we;
  logic [31:0]   r_addr;
  logic [3:0]    r_be;
  logic [31:0]   r_wdata;
  logic [31:0]   r_rdata;
  logic          r_err;
  logic [7:0]    r_err_cnt;
  logic          w_timer_done;
  logic          w_latch_cmd;
  logic          w_capture;
  logic          w_timeout;

  // The timer counts from 0 on entry, so the last allowed cycle sees BUS_TIMEOUT-1.
  assign w_timer_done = (r_timer == TW'(BUS_TIMEOUT - 1));

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  // Next state and datapath strobes; ack/resp are tested before the timeout so they win a tie.
  always_comb begin
    w_next_state = r_state;
    w_latch_cmd  = 1'b0;
    w_capture    = 1'b0;
    w_timeout    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (cmd_req_i) begin
          w_latch_cmd  = 1'b1;
          w_next_state = S_REQ;
        end
      end
      S_REQ: begin
        if (bus_ack_i) begin
          if (r_we) begin
            w_next_state = S_IDLE;
          end else if (bus_resp_i) begin
            w_capture    = 1'b1;
            w_next_state = S_RESP_OUT;
          end else begin
            w_next_state = S_WAIT_RESP;
          end
        end else if (w_timer_done) begin
          w_timeout    = 1'b1;
          w_next_state = r_we ? S_IDLE : S_RESP_OUT;
        end
      end
      S_WAIT_RESP: begin
        if (bus_resp_i) begin
          w_capture    = 1'b1;
          w_next_state = S_RESP_OUT;
        end else if (w_timer_done) begin
          w_timeout    = 1'b1;
          w_next_state = S_RESP_OUT;
        end
      end
      S_RESP_OUT: begin
        if (resp_ack_i) w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // Command registers drive the bus directly and stay stable for the whole transaction.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_be    <= '0;
      r_wdata <= '0;
    end else if (w_latch_cmd) begin
      r_we    <= cmd_we_i;
      r_addr  <= cmd_addr_bi;
      r_be    <= cmd_be_bi;
      r_wdata <= cmd_wdata_bi;
    end
  end

  // Timer restarts on every state change and runs only while waiting on the bus.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_timer <= '0;
    end else if (w_next_state != r_state) begin
      r_timer <= '0;
    end else if (r_state == S_REQ || r_state == S_WAIT_RESP) begin
      r_timer <= r_timer + TW'(1);
    end
  end

  // Response data/error capture; a write timeout leaves the response registers untouched.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else if (w_capture) begin
      r_rdata <= bus_rdata_bi;
      r_err   <= 1'b0;
    end else if (w_timeout && !r_we) begin
      r_rdata <= TIMEOUT_RDATA;
      r_err   <= 1'b1;
    end
  end

  // Saturating count of ack and resp timeouts.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_err_cnt <= '0;
    end else if (w_timeout && r_err_cnt != 8'hFF) begin
      r_err_cnt <= r_err_cnt + 8'd1;
    end
  end

  assign cmd_ack_o     = (r_state == S_IDLE);
  assign busy_o        = (r_state != S_IDLE);
  assign bus_req_o     = (r_state == S_REQ);
  assign resp_req_o    = (r_state == S_RESP_OUT);
  assign bus_we_o      = r_we;
  assign bus_addr_bo   = r_addr;
  assign bus_be_bo     = r_be;
  assign bus_wdata_bo  = r_wdata;
  assign resp_rdata_bo = r_rdata;
  assign resp_err_o    = r_err;
  assign err_cnt_bo    = r_err_cnt;

endmodule
